multi_cycle_control_fsm: RTL and testbench
==========================================

# multi_cycle_control_fsm

Main control unit of the multi-cycle RISC-V core: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback steps. It sits directly upstream of the ALU. It drives the 3-bit ALU operation code in the ALU's own encoding, together with the operand-select, result-select and write-enable strobes for the datapath. It consumes the ALU zero flag to resolve `beq`.

## Interface
- No parameters.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; forces state to FETCH.
- `op` input 7: instruction[6:0] from the instruction register.
- `funct3` input 3: instruction[14:12].
- `funct7b5` input 1: instruction[30].
- `zero` input 1: ALU zero flag, same cycle.
- `ALUControl` output 3: ALU operation.
  - 000 add, 001 sub, 010 and, 011 xor, 101 slt, 110 or, 111 default.
- `ALUSrcA` output 2: 00 PC, 01 OldPC, 10 register A.
- `ALUSrcB` output 2: 00 register B, 01 ImmExt, 10 constant 4.
- `ResultSrc` output 2: 00 ALUOut register, 01 memory data register, 10 live ALU result.
- `AdrSrc` output 1: memory address; 0 PC, 1 Result.
- `IRWrite`, `PCWrite`, `RegWrite`, `MemWrite` output 1 each: write enables.
- `state` output 4: current state encoding, for debug and verification.
- `instr_done` output 1: high in the last cycle of every instruction.

## Operation
- State encodings:
  - 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMREAD, 4 MEMWB, 5 MEMWRITE
  - 6 EXECR, 7 EXECI, 8 ALUWB, 9 BEQ, 10 JAL
- Outputs are purely a function of `state`, plus `op`/`funct3`/`funct7b5` for the ALU op and `zero` in BEQ. Any output not listed for a state is 0; `ALUControl` defaults to 000.
- Per-state outputs and transitions:
  - FETCH: AdrSrc 0, IRWrite 1, ALUSrcA 00, ALUSrcB 10, add, ResultSrc 10, PCWrite 1. Next: DECODE.
  - DECODE: ALUSrcA 01, ALUSrcB 01, add (branch target into ALUOut). Next, by `op`:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BEQ
    - 1101111 → JAL
    - any other value → FETCH, with `instr_done` = 1 (illegal op retires as a no-op).
  - MEMADR: ALUSrcA 10, ALUSrcB 01, add. Next: MEMREAD if op = 0000011, else MEMWRITE.
  - MEMREAD: ResultSrc 00, AdrSrc 1. Next: MEMWB.
  - MEMWB: ResultSrc 01, RegWrite 1, `instr_done` 1. Next: FETCH.
  - MEMWRITE: ResultSrc 00, AdrSrc 1, MemWrite 1, `instr_done` 1. Next: FETCH.
  - EXECR: ALUSrcA 10, ALUSrcB 00, ALU op from funct decode. Next: ALUWB.
  - EXECI: ALUSrcA 10, ALUSrcB 01, ALU op from funct decode. Next: ALUWB.
  - ALUWB: ResultSrc 00, RegWrite 1, `instr_done` 1. Next: FETCH.
  - BEQ: ALUSrcA 10, ALUSrcB 00, sub, ResultSrc 00, PCWrite = `zero`, `instr_done` 1. Next: FETCH.
  - JAL: ALUSrcA 01, ALUSrcB 10, add, ResultSrc 00, PCWrite 1. Next: ALUWB (writes PC+4 to rd).
- Funct decode (EXECR/EXECI only):
  - funct3 000: sub (001) if op = 0110011 and funct7b5 = 1; otherwise add (000). addi ignores funct7b5.
  - funct3 010 → slt (101); 100 → xor (011); 110 → or (110); 111 → and (010).
  - Any other funct3 → 111 (ALU default).
- Unreachable state encodings 11–15: all outputs 0; next state FETCH.

## Timing
- Cycles per instruction: lw 5, sw 4, R-type 4, I-type ALU 4, jal 4, beq 3, illegal 2.
- Exactly one `instr_done` pulse per instruction; no cycle without a state change.
- Reset behaviour:
  - While `reset` = 1: `state` = 0 and IRWrite, PCWrite, RegWrite, MemWrite, `instr_done` are forced to 0. The remaining outputs take their FETCH values.
  - First FETCH executes in the first clock edge after `reset` deasserts.
  - Reset asserted mid-instruction: state goes to FETCH immediately (asynchronous), and in-flight writes are suppressed in that same cycle.
- `zero` is sampled combinationally only in BEQ. `zero` = 1 in any other state has no effect.

## Test plan
- Reset mid-MEMREAD of lw (op 0000011) → `state` = 0 asynchronously; all write enables 0; after release the sequence restarts FETCH → DECODE.
- lw: states 0, 1, 2, 3, 4 → `RegWrite` = 1 only in state 4 with ResultSrc 01, `instr_done` pulses once, back to 0; sw: states 0, 1, 2, 5 → `MemWrite` = 1 only in state 5.
- R-type sub (funct3 000, funct7b5 1) → `ALUControl` = 001 in EXECR; the same fields with op 0010011 (addi) → 000; funct3 111 → 010, 110 → 110, 100 → 011, 010 → 101, 001 → 111.
- beq with `zero` = 1 → `PCWrite` = 1 and ALUControl 001 in BEQ; with `zero` = 0 → `PCWrite` = 0; 3 cycles each.
- jal: states 0, 1, 10, 8 → PCWrite 1 in JAL with ALUSrcA 01, ALUSrcB 10; RegWrite 1 in ALUWB.
- Illegal op 0000000 → DECODE returns to FETCH with `instr_done` = 1 and no RegWrite or MemWrite asserted.

Source files
------------

// File: rtl/multi_cycle_control_fsm.sv
// Multi-cycle RISC-V main control FSM. It is a Moore sequencer that drives the ALU
// op code, the datapath mux selects and the write strobes for each instruction step.
module multi_cycle_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic [2:0] ALUControl,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] state,
  output logic       instr_done
);
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  logic [3:0] r_state, w_next;
  logic [2:0] w_funct_op;
  logic       w_irw, w_pcw, w_rw, w_mw, w_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Only R-type sub honours funct7b5; addi with bit 30 set is still an add.
  always_comb begin
    w_funct_op = 3'b111;
    case (funct3)
      3'b000:  w_funct_op = (op == OP_R && funct7b5) ? 3'b001 : 3'b000;
      3'b010:  w_funct_op = 3'b101;
      3'b100:  w_funct_op = 3'b011;
      3'b110:  w_funct_op = 3'b110;
      3'b111:  w_funct_op = 3'b010;
      default: w_funct_op = 3'b111;
    endcase
  end

  always_comb begin
    w_next     = S_FETCH;
    ALUControl = 3'b000;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    AdrSrc     = 1'b0;
    w_irw      = 1'b0;
    w_pcw      = 1'b0;
    w_rw       = 1'b0;
    w_mw       = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        w_irw     = 1'b1;
        w_pcw     = 1'b1;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_BEQ:       w_next = S_BEQ;
          OP_JAL:       w_next = S_JAL;
          default: begin
            w_next = S_FETCH;
            w_done = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        w_next  = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        w_rw      = 1'b1;
        w_done    = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        w_mw   = 1'b1;
        w_done = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = w_funct_op;
        w_next     = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = w_funct_op;
        w_next     = S_ALUWB;
      end
      S_ALUWB: begin
        w_rw   = 1'b1;
        w_done = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        ALUControl = 3'b001;
        w_pcw      = zero;
        w_done     = 1'b1;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        w_pcw   = 1'b1;
        w_next  = S_ALUWB;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Writes are gated by reset so an aborted instruction commits nothing.
  assign IRWrite    = w_irw  & ~reset;
  assign PCWrite    = w_pcw  & ~reset;
  assign RegWrite   = w_rw   & ~reset;
  assign MemWrite   = w_mw   & ~reset;
  assign instr_done = w_done & ~reset;
  assign state      = r_state;
endmodule

// File: tb/tb_multi_cycle_control_fsm.sv
// Directed table-driven bench for multi_cycle_control_fsm with hand-written reset corner cases.
module tb_multi_cycle_control_fsm;
  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero;
  logic [2:0] ALUControl;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, instr_done;
  logic [3:0] state;

  multi_cycle_control_fsm dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .ALUControl(ALUControl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .state(state), .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic [3:0]  st;
    logic [14:0] out;
  } vec_t;

  vec_t tbl[$];
  int   passed = 0, total = 0;
  logic [14:0] act;
  assign act = {ALUControl, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc,
                IRWrite, PCWrite, RegWrite, MemWrite, instr_done};

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111, IL = 7'b0000000;

  function automatic logic [14:0] o(logic [2:0] alu, logic [1:0] sa, logic [1:0] sb,
                                    logic [1:0] rs, logic adr, logic irw, logic pcw,
                                    logic rw, logic mw, logic dn);
    return {alu, sa, sb, rs, adr, irw, pcw, rw, mw, dn};
  endfunction

  function automatic vec_t mk(logic [6:0] op_i, logic [2:0] f3, logic f7, logic z,
                              logic [3:0] st, logic [14:0] out);
    vec_t v;
    v.op = op_i; v.f3 = f3; v.f7 = f7; v.z = z; v.st = st; v.out = out;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [14:0] got, logic [14:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s #%0d: got %h want %h", name, idx, got, exp);
  endtask

  task automatic apply(vec_t v);
    op = v.op; funct3 = v.f3; funct7b5 = v.f7; zero = v.z;
  endtask

  task automatic run(vec_t v, int idx);
    apply(v);
    #2;
    chk("state", idx, {11'd0, state}, {11'd0, v.st});
    chk("outs", idx, act, v.out);
    @(posedge clk); #1;
  endtask

  // Common per-state expectations
  logic [14:0] O_F, O_D, O_DILL, O_MA, O_MR, O_MWB, O_MW, O_WB, O_JAL, O_RST;

  task automatic add_r(logic [6:0] opc, logic [2:0] f3, logic f7, logic z,
                       logic [3:0] ex_st, logic [14:0] ex_out);
    tbl.push_back(mk(opc, f3, f7, z, 4'd0, O_F));
    tbl.push_back(mk(opc, f3, f7, z, 4'd1, O_D));
    tbl.push_back(mk(opc, f3, f7, z, ex_st, ex_out));
    tbl.push_back(mk(opc, f3, f7, z, 4'd8, O_WB));
  endtask

  initial begin
    O_F    = o(3'b000, 2'b00, 2'b10, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    O_RST  = o(3'b000, 2'b00, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    O_D    = o(3'b000, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    O_DILL = o(3'b000, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    O_MA   = o(3'b000, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    O_MR   = o(3'b000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    O_MWB  = o(3'b000, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    O_MW   = o(3'b000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    O_WB   = o(3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    O_JAL  = o(3'b000, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // lw: 0,1,2,3,4
    tbl.push_back(mk(LW, 3'b010, 1'b0, 1'b0, 4'd0, O_F));
    tbl.push_back(mk(LW, 3'b010, 1'b0, 1'b0, 4'd1, O_D));
    tbl.push_back(mk(LW, 3'b010, 1'b0, 1'b0, 4'd2, O_MA));
    tbl.push_back(mk(LW, 3'b010, 1'b0, 1'b0, 4'd3, O_MR));
    tbl.push_back(mk(LW, 3'b010, 1'b0, 1'b0, 4'd4, O_MWB));
    // sw: 0,1,2,5 (zero high has no effect outside BEQ)
    tbl.push_back(mk(SW, 3'b010, 1'b0, 1'b1, 4'd0, O_F));
    tbl.push_back(mk(SW, 3'b010, 1'b0, 1'b1, 4'd1, O_D));
    tbl.push_back(mk(SW, 3'b010, 1'b0, 1'b1, 4'd2, O_MA));
    tbl.push_back(mk(SW, 3'b010, 1'b0, 1'b1, 4'd5, O_MW));
    // R-type / I-type funct decode
    add_r(RT, 3'b000, 1'b1, 1'b1, 4'd6, o(3'b001, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    add_r(IT, 3'b000, 1'b1, 1'b0, 4'd7, o(3'b000, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    add_r(RT, 3'b000, 1'b0, 1'b0, 4'd6, o(3'b000, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    add_r(RT, 3'b111, 1'b0, 1'b0, 4'd6, o(3'b010, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    add_r(RT, 3'b110, 1'b0, 1'b0, 4'd6, o(3'b110, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    add_r(IT, 3'b100, 1'b0, 1'b0, 4'd7, o(3'b011, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    add_r(RT, 3'b010, 1'b0, 1'b0, 4'd6, o(3'b101, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    add_r(RT, 3'b001, 1'b0, 1'b0, 4'd6, o(3'b111, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    add_r(IT, 3'b101, 1'b1, 1'b0, 4'd7, o(3'b111, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    // beq taken / not taken: 3 cycles each
    tbl.push_back(mk(BQ, 3'b000, 1'b0, 1'b1, 4'd0, O_F));
    tbl.push_back(mk(BQ, 3'b000, 1'b0, 1'b1, 4'd1, O_D));
    tbl.push_back(mk(BQ, 3'b000, 1'b0, 1'b1, 4'd9, o(3'b001, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1)));
    tbl.push_back(mk(BQ, 3'b000, 1'b0, 1'b0, 4'd0, O_F));
    tbl.push_back(mk(BQ, 3'b000, 1'b0, 1'b0, 4'd1, O_D));
    tbl.push_back(mk(BQ, 3'b000, 1'b0, 1'b0, 4'd9, o(3'b001, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)));
    // jal: 0,1,10,8
    add_r(JL, 3'b000, 1'b0, 1'b0, 4'd10, O_JAL);
    // illegal op: 0,1 then back to FETCH
    tbl.push_back(mk(IL, 3'b000, 1'b0, 1'b0, 4'd0, O_F));
    tbl.push_back(mk(IL, 3'b000, 1'b0, 1'b0, 4'd1, O_DILL));
    tbl.push_back(mk(IL, 3'b000, 1'b0, 1'b0, 4'd0, O_F));

    reset = 1'b1;
    apply(tbl[0]);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 0, {11'd0, state}, 15'd0);
    chk("rst_outs", 0, act, O_RST);
    reset = 1'b0;

    for (int i = 0; i < tbl.size() - 1; i++) run(tbl[i], i);

    // Reset asserted mid-MEMREAD of lw
    for (int i = 0; i < 3; i++) run(tbl[i], 100 + i);
    #2;
    chk("memread_state", 103, {11'd0, state}, 15'd3);
    reset = 1'b1;
    #1;
    chk("async_rst_state", 104, {11'd0, state}, 15'd0);
    chk("async_rst_outs", 104, act, O_RST);
    @(posedge clk); #1;
    chk("held_rst_outs", 105, act, O_RST);
    reset = 1'b0;
    run(tbl[0], 106);
    run(tbl[1], 107);

    // Reset in MEMWB suppresses the in-flight RegWrite
    run(tbl[2], 108);
    run(tbl[3], 109);
    #2;
    chk("memwb_outs", 110, act, O_MWB);
    reset = 1'b1;
    #1;
    chk("memwb_rst_state", 111, {11'd0, state}, 15'd0);
    chk("memwb_rst_outs", 111, act, O_RST);
    @(posedge clk); #1;
    reset = 1'b0;
    run(tbl[0], 112);
    run(tbl[1], 113);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end
endmodule
